// File: rtl/sync_read_regfile_if.sv
// Bus bundle for sync_read_regfile: one write port plus a paired read request
// that returns two registered read results and a valid flag.
interface sync_read_regfile_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
);
  logic              writeEnable;
  logic [ADDR_W-1:0] writeReg;
  logic [WIDTH-1:0]  writeData;
  logic              readReq;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [WIDTH-1:0]  readData1;
  logic [WIDTH-1:0]  readData2;
  logic              readValid;

  // The requester drives strobes and addresses and consumes the read results.
  modport master (
    output writeEnable, writeReg, writeData,
    output readReq, readReg1, readReg2,
    input  readData1, readData2, readValid
  );

  // The register file accepts requests and returns registered read results.
  modport slave (
    input  writeEnable, writeReg, writeData,
    input  readReq, readReg1, readReg2,
    output readData1, readData2, readValid
  );
endinterface

// File: rtl/sync_read_regfile.sv
// sync_read_regfile: 32 x 64-bit register file with one write port and two
// synchronous read ports. Register 31 is hardwired to zero. Read results and
// readValid come from flops one cycle after an accepted readReq.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read that hits
// the address being written on the same edge returns the new writeData
// (per port); when undefined it returns the pre-write contents.
module sync_read_regfile #(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  sync_read_regfile_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] nextData1;
  logic [WIDTH-1:0] nextData2;
  logic             writeHit1;
  logic             writeHit2;

  // Detect a same-edge write to the address each read port is requesting;
  // the zero register never takes part in a collision.
  always_comb begin
    writeHit1 = 1'b0;
    writeHit2 = 1'b0;
    if (bus.writeEnable && bus.writeReg != ZERO_REG) begin
      writeHit1 = (bus.writeReg == bus.readReg1);
      writeHit2 = (bus.writeReg == bus.readReg2);
    end
  end

  // Select the value each port will capture: zero for register 31, optionally
  // the in-flight write data on a collision, otherwise the stored entry.
  always_comb begin
    nextData1 = mem[bus.readReg1];
    nextData2 = mem[bus.readReg2];
`ifdef REGFILE_BYPASS_EN
    if (writeHit1) nextData1 = bus.writeData;
    if (writeHit2) nextData2 = bus.writeData;
`else
    if (writeHit1 && writeHit2) begin
      nextData1 = mem[bus.readReg1];
      nextData2 = mem[bus.readReg2];
    end
`endif
    if (bus.readReg1 == ZERO_REG) nextData1 = '0;
    if (bus.readReg2 == ZERO_REG) nextData2 = '0;
  end

  // Storage update: reset clears every entry, writes to register 31 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.writeEnable && bus.writeReg != ZERO_REG) begin
      mem[bus.writeReg] <= bus.writeData;
    end
  end

  // Read result registers: capture on an accepted request, otherwise hold data
  // and drop readValid so it is high for exactly one cycle per request.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.readData1 <= '0;
      bus.readData2 <= '0;
      bus.readValid <= 1'b0;
    end else if (bus.readReq) begin
      bus.readData1 <= nextData1;
      bus.readData2 <= nextData2;
      bus.readValid <= 1'b1;
    end else begin
      bus.readValid <= 1'b0;
    end
  end

endmodule

// File: doc/sync_read_regfile.md
# sync_read_regfile

Synchronous-read register file for the 64-bit datapath: 32 entries of 64 bits, one write port and two read ports. Reads are requested with a single strobe and returned registered one cycle later with a valid flag. It is the read-side companion to the per-register write-enable storage already used in the CPU. Register 31 is hardwired to zero (XZR semantics).

## Interface
- `DEPTH`, 32: number of entries; fixed at 32.
- `WIDTH`, 64: data width in bits.
- `ADDR_W`, 5: register address width; must equal log2(`DEPTH`).
- `clk`  in  1  : single clock; all state updates on the rising edge.
- `reset`  in  1  : synchronous, active-high; sampled on the rising edge of `clk`.
- `writeEnable`  in  1  : write strobe.
- `writeReg`  in  ADDR_W  : write address.
- `writeData`  in  WIDTH  : write data.
- `readReq`  in  1  : read request strobe for both read ports.
- `readReg1`  in  ADDR_W  : port-1 read address.
- `readReg2`  in  ADDR_W  : port-2 read address.
- `readData1`  out  WIDTH  : registered port-1 data.
- `readData2`  out  WIDTH  : registered port-2 data.
- `readValid`  out  1  : high for exactly the cycle after an accepted `readReq`.

## Operation
- Storage holds 32 × 64-bit entries.
- Entry 31 always reads 64'h0. Writes to address 31 are discarded.
- Write: on a rising edge with `writeEnable`=1 and `reset`=0, `mem[writeReg]` <= `writeData`.
- Read: on a rising edge with `readReq`=1 and `reset`=0:
  - `readData1` <= `mem[readReg1]`
  - `readData2` <= `mem[readReg2]`
  - `readValid` <= 1
- With `readReq`=0: `readData1` and `readData2` hold their previous values, and `readValid` <= 0.
- Both ports may use the same address; both then return the same value.
- Read/write collision: a read and a write to the same nonzero address on the same edge. The value returned depends on `REGFILE_BYPASS_EN` (see Configuration).
- Reset has priority over reads and writes:
  - all 32 entries <= 0
  - `readData1` = `readData2` = 0
  - `readValid` = 0
  - any read or write presented on the reset edge is dropped.
- Reset asserted mid-stream: `readValid` goes low on the next edge. No pending read survives reset.

## Timing
- Write latency: 1 edge. Data is visible to a read requested on any later edge.
- Read latency: 1 cycle. Request at edge N means data and `readValid` are valid after edge N, for cycle N+1.
- Back-to-back reads: `readReq` held high gives one result per cycle, and `readValid` stays high continuously.
- No backpressure. The consumer must capture results in the `readValid` cycle. Data then holds until the next accepted request or reset.
- Outputs are driven only from flops; there is no combinational path from inputs to outputs.
- State after reset: all outputs 0, all entries 0.

## Configuration
- `REGFILE_BYPASS_EN` defined (forwarding): on a same-edge read/write collision, the read port returns the new `writeData`.
  - Address 31 is still 0.
  - The bypass is applied independently per port.
- `REGFILE_BYPASS_EN` undefined (no forwarding): a colliding read returns the pre-write contents. The new value is visible from the next edge onward.
- The write behaviour is identical in both builds.

## Test plan
- Reset then read: assert `reset` for 1 edge, then `readReq`=1 with `readReg1`=0 and `readReg2`=30 → next cycle `readData1`=`readData2`=0 and `readValid`=1.
- Write then read: write 64'h0000010204080001 to reg 5; on a later edge read reg 5 on both ports → both ports return 64'h0000010204080001 and `readValid`=1 for one cycle.
- Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to reg 31, then read reg 31 → 0 on both ports; reg 30 is unchanged.
- Collision: reg 7 holds 64'hA0. On the same edge, write 64'hB0 to reg 7 and read reg 7 on port 1 → 64'hB0 with `REGFILE_BYPASS_EN`, 64'hA0 without. A read on the following edge → 64'hB0 in both builds.
- Hold and streaming: read reg 1 then reg 2 on consecutive edges, then drop `readReq` → `readValid` is 1,1,0; `readData1` steps through mem[1] and mem[2], then holds mem[2].
- Reset mid-operation: hold `readReq`=1 and `writeEnable`=1 while asserting `reset` → next cycle `readValid`=0, outputs are 0, and the write is dropped (a later read of that register returns 0).
